// File: rtl/systolic_pkg.sv
// Shared types for the systolic-array bottom-edge drain: state encoding and
// row-count width. Pure declarations, no logic, no latency.
package systolic_pkg;

  localparam int ADD_BW_DEF = 32;
  localparam int ROW_CNT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } drain_state_t;

endpackage

// File: rtl/drain_fifo.sv
// First-word-fall-through row FIFO; a push is visible on o_data next cycle.
// Push while full is accepted only when a pop happens the same cycle; pop while empty is ignored.
module drain_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | i_pop);
  // Empty FIFO presents zero so the output is clean after reset without resetting the array.
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/systolic_drain.sv
// De-skews the array bottom edge into whole rows (N_COLS-1 cycles) and queues them; rows surface one cycle later.
// Consumer backpressure stalls the FIFO; rows arriving while it is full are dropped and flagged in o_overflow.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int N_COLS = 4,
  parameter int ADD_BW = ADD_BW_DEF,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_mode,
  input  logic [N_COLS*ADD_BW-1:0]   i_col_data,
  input  logic                       i_row_valid,
  input  logic                       i_start,
  input  logic [ROW_CNT_W-1:0]       i_num_rows,
  output logic [N_COLS*ADD_BW-1:0]   o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_overflow,
  output logic [ROW_CNT_W-1:0]       o_rows
);

  localparam int LAT = N_COLS - 1;
  localparam int RW  = N_COLS * ADD_BW;
  localparam logic [ROW_CNT_W-1:0] ONE_ROW = ROW_CNT_W'(1);

  drain_state_t           r_state;
  logic [ROW_CNT_W-1:0]   r_num_rows;
  logic [ROW_CNT_W-1:0]   r_rows;
  logic                   r_overflow;
  logic                   r_busy;
  logic                   r_done;

  logic [RW-1:0]          w_row_dat;
  logic                   w_elig;
  logic                   w_row_vld;
  logic                   w_push;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_fifo_count;

  // Column j leaves the array j cycles after column 0, so it needs LAT-j cycles of delay.
  for (genvar j = 0; j < N_COLS; j++) begin : g_col
    localparam int D = N_COLS - 1 - j;
    if (D == 0) begin : g_pass
      assign w_row_dat[j*ADD_BW +: ADD_BW] = i_col_data[j*ADD_BW +: ADD_BW];
    end else begin : g_dly
      logic [ADD_BW-1:0] r_pipe [D];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < D; k++) r_pipe[k] <= '0;
        end else begin
          r_pipe[0] <= i_col_data[j*ADD_BW +: ADD_BW];
          for (int k = 1; k < D; k++) r_pipe[k] <= r_pipe[k-1];
        end
      end
      assign w_row_dat[j*ADD_BW +: ADD_BW] = r_pipe[D-1];
    end
  end

  // Eligibility is judged when column 0 is sampled and then rides along with the valid.
  assign w_elig = i_row_valid & i_mode & (r_state == S_COLLECT);

  if (LAT == 0) begin : g_vld_pass
    assign w_row_vld = w_elig;
  end else begin : g_vld_dly
    logic [LAT-1:0] r_vld_sr;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_vld_sr <= '0;
      else      r_vld_sr <= (r_vld_sr << 1) | LAT'(w_elig);
    end
    assign w_row_vld = r_vld_sr[LAT-1];
  end

  assign w_push = w_row_vld & (r_state == S_COLLECT);

  drain_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_row_dat),
    .i_pop   (i_ready),
    .o_data  (o_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_num_rows <= '0;
      r_rows     <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_num_rows <= i_num_rows;
            r_rows     <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= (i_num_rows == '0) ? S_DRAIN : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (w_row_vld) begin
            r_rows <= r_rows + ONE_ROW;
            if (w_full & ~i_ready) r_overflow <= 1'b1;
            if (r_rows + ONE_ROW == r_num_rows) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_fifo_count == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_valid    = ~w_empty;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_overflow = r_overflow;
  assign o_rows     = r_rows;

endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 Parameter: N_COLS, 4, number of array columns drained (one per bottom-edge PE).
REQ-002 Parameter: ADD_BW, 32, width of each column result (bfp32).
REQ-003 Parameter: DEPTH, 8, output FIFO depth in rows; power of two.
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-low.
REQ-006 Port: i_mode  in  1  array mode: 0 = weight load (bottom data is pass-through, ignored), 1 = accumulate.
REQ-007 Port: i_col_data  in  N_COLS*ADD_BW  bottom-edge outputs of the array, column j in bits [j*ADD_BW +: ADD_BW].
REQ-008 Port: i_row_valid  in  1  column 0 holds a valid result row this cycle; column j holds that row j cycles later.
REQ-009 Port: i_start  in  1  one-cycle pulse that begins a collection job.
REQ-010 Port: i_num_rows  in  8  rows to collect; sampled on i_start.
REQ-011 Port: o_data  out  N_COLS*ADD_BW  head-of-FIFO de-skewed row.
REQ-012 Port: o_valid  out  1  FIFO not empty.
REQ-013 Port: i_ready  in  1  consumer accepts o_data when o_valid & i_ready.
REQ-014 Port: o_busy  out  1  state is not IDLE.
REQ-015 Port: o_done  out  1  one-cycle pulse at job end.
REQ-016 Port: o_overflow  out  1  sticky: a row was dropped because the FIFO was full.
REQ-017 Port: o_rows  out  8  rows captured (written or dropped) in current job.

Function
REQ-018 De-skew: column j delayed N_COLS-1-j cycles and i_row_valid delayed N_COLS-1 cycles, so one row emerges aligned at t+N_COLS-1.
REQ-019 Qualifier: a row is eligible only if i_mode=1 and state=COLLECT on the cycle i_row_valid is sampled; qualifier travels with the delayed valid.
REQ-020 States: IDLE, COLLECT, DRAIN, DONE.
REQ-021 IDLE -> COLLECT on i_start; latch i_num_rows, clear o_rows and o_overflow; i_num_rows=0 goes directly to DRAIN.
REQ-022 COLLECT: each aligned eligible row increments o_rows; pushed if FIFO not full (or popped same cycle), else dropped with o_overflow set.
REQ-023 COLLECT -> DRAIN on the cycle o_rows reaches the latched count; later valid rows are ignored.
REQ-024 DRAIN -> DONE when FIFO empty; DONE asserts o_done for exactly one cycle, then -> IDLE.
REQ-025 i_start outside IDLE is ignored.
REQ-026 FIFO: first-word-fall-through; written row visible on o_data the cycle after the push.
REQ-027 Simultaneous push and pop when full: both succeed, occupancy unchanged; pop when empty ignored.
REQ-028 FIFO pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
REQ-029 Popping continues in every state, including IDLE (leftover rows from an aborted job are not auto-flushed).
REQ-030 o_data is unchanged while o_valid & ~i_ready (stable under backpressure).

Reset
REQ-031 On rst=0: state IDLE, FIFO empty, de-skew pipeline and delayed valids cleared; o_valid, o_busy, o_done, o_overflow 0; o_rows 0; o_data 0.
REQ-032 Reset mid-job discards all in-flight and buffered rows; no o_done is produced.

Structure
REQ-033 Shared package systolic_pkg holds ADD_BW default, the drain state enum, and the row-count width constant.
REQ-034 FIFO is a sub-module drain_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-035 N_COLS=4, start num_rows=2, inject rows {1,2,3,4},{5,6,7,8} with column skew -> o_data rows in order, each aligned, first o_valid at t0+4, o_done after second pop.
REQ-036 i_mode=0 with i_row_valid pulses during COLLECT -> no FIFO writes, o_rows stays 0.
REQ-037 DEPTH=8, i_ready=0, num_rows=10 -> 8 rows stored, 2 dropped, o_overflow=1, o_rows=10, then drain 8 and o_done.
REQ-038 FIFO full, push and pop on same cycle -> count stays 8, popped row is oldest, pushed row appears last.
REQ-039 num_rows=0 start -> DRAIN, DONE, o_done pulse within 2 cycles, no writes.
REQ-040 Assert rst=0 after 3 of 5 rows collected -> outputs per REQ-031 next cycle, no o_done; new job afterward runs normally.
